ccm_sram_ctl: RTL and testbench

Controller and two-port arbiter for a single-port 39-bit CCM SRAM macro (32 data bits + 7 ECC bits, default 2048 deep). After reset it zero-fills the whole array so that every word carries valid ECC. It then shares the macro between a core port (p0) and a DMA port (p1) with round-robin arbitration and a fixed 1-cycle read latency. It sits between the LSU/DMA request logic and the SRAM macro instance; ECC generation and checking stay outside this block.

---
 rtl/ccm_sram_ctl.sv | 141 ++++++++++++++
 tb/tb_ccm_sram_ctl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccm_sram_ctl.sv
// ccm_sram_ctl: zero-fills a single-port CCM SRAM after reset, then shares it
// between a core port (p0) and a DMA port (p1) using round-robin arbitration.
// Reads return one cycle after their grant. ECC is handled outside this block.
module ccm_sram_ctl #(
   parameter int                ADDR_W   = 11,
   parameter int                DATA_W   = 39,
   parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_req,
   output logic              init_done,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] ram_adr,
   output logic [DATA_W-1:0] ram_d,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q
);

   // Last word of the array; the sweep stops here instead of wrapping.
   localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};

   typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_init_cnt, w_init_cnt_nxt;
   logic              r_rr_last, w_rr_last_nxt;
   logic              r_rvld0_p1, r_rvld1_p1;
   logic              w_gnt0, w_gnt1;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_adr;
   logic [DATA_W-1:0] w_ram_d;

   // State, sweep counter and round-robin pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_INIT;
         r_init_cnt <= '0;
         r_rr_last  <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_init_cnt <= w_init_cnt_nxt;
         r_rr_last  <= w_rr_last_nxt;
      end
   end

   // Next state, arbitration and SRAM command mux; everything is forced
   // idle while rst is high so outputs drop immediately with the reset.
   always_comb begin
      w_state_nxt    = r_state;
      w_init_cnt_nxt = r_init_cnt;
      w_rr_last_nxt  = r_rr_last;
      w_gnt0         = 1'b0;
      w_gnt1         = 1'b0;
      w_ram_we       = 1'b0;
      w_ram_adr      = '0;
      w_ram_d        = '0;
      case (r_state)
         S_INIT: begin
            w_ram_we  = 1'b1;
            w_ram_adr = r_init_cnt;
            w_ram_d   = INIT_VAL;
            if (r_init_cnt == CNT_MAX) begin
               w_state_nxt    = S_RUN;
               w_init_cnt_nxt = '0;
            end else begin
               w_init_cnt_nxt = r_init_cnt + 1'b1;
            end
         end
         S_RUN: begin
            if (init_req) begin
               w_state_nxt = S_INIT;
            end else begin
               // p0 wins unless p1 also asks and p0 had the last grant.
               if (p0_req && (!p1_req || r_rr_last)) begin
                  w_gnt0 = 1'b1;
               end else if (p1_req) begin
                  w_gnt1 = 1'b1;
               end
               if (w_gnt0) begin
                  w_ram_we      = p0_we;
                  w_ram_adr     = p0_addr;
                  w_ram_d       = p0_wdata;
                  w_rr_last_nxt = 1'b0;
               end else if (w_gnt1) begin
                  w_ram_we      = p1_we;
                  w_ram_adr     = p1_addr;
                  w_ram_d       = p1_wdata;
                  w_rr_last_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_INIT;
         end
      endcase
      if (rst) begin
         w_gnt0    = 1'b0;
         w_gnt1    = 1'b0;
         w_ram_we  = 1'b0;
         w_ram_adr = '0;
         w_ram_d   = '0;
      end
   end

   // Read-response tracking: remembers which port issued a read last cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rvld0_p1 <= 1'b0;
         r_rvld1_p1 <= 1'b0;
      end else begin
         r_rvld0_p1 <= w_gnt0 & ~p0_we;
         r_rvld1_p1 <= w_gnt1 & ~p1_we;
      end
   end

   assign init_done = (r_state == S_RUN);
   assign p0_gnt    = w_gnt0;
   assign p1_gnt    = w_gnt1;
   assign ram_we    = w_ram_we;
   assign ram_adr   = w_ram_adr;
   assign ram_d     = w_ram_d;
   assign p0_rvalid = r_rvld0_p1;
   assign p1_rvalid = r_rvld1_p1;
   assign p0_rdata  = r_rvld0_p1 ? ram_q : '0;
   assign p1_rdata  = r_rvld1_p1 ? ram_q : '0;

endmodule

// File: tb/tb_ccm_sram_ctl.sv
// Bench for ccm_sram_ctl: SRAM macro model plus a read scoreboard.
module tb_ccm_sram_ctl;

   localparam int AW    = 11;
   localparam int DW    = 39;
   localparam int DEPTH = 2**AW;

   typedef struct packed {
      logic          port;
      logic [DW-1:0] data;
   } rd_exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          init_req;
   logic          init_done;
   logic          p0_req, p0_we, p0_gnt, p0_rvalid;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_wdata, p0_rdata;
   logic          p1_req, p1_we, p1_gnt, p1_rvalid;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_wdata, p1_rdata;
   logic [AW-1:0] ram_adr;
   logic [DW-1:0] ram_d;
   logic          ram_we;
   logic [DW-1:0] ram_q;

   logic [DW-1:0] mem     [0:DEPTH-1];
   logic [DW-1:0] ref_mem [0:DEPTH-1];
   rd_exp_t       sbq[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic          g0, g1;

   ccm_sram_ctl #(.ADDR_W(AW), .DATA_W(DW), .INIT_VAL({DW{1'b0}})) dut (
      .clk(clk), .rst(rst), .init_req(init_req), .init_done(init_done),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .ram_adr(ram_adr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   // Single-port SRAM macro with registered read output.
   always @(posedge clk) begin
      if (ram_we) mem[ram_adr] <= ram_d;
      else        ram_q <= mem[ram_adr];
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Negedge sample: retire last cycle's read, then log this cycle's grant.
   task automatic sample();
      rd_exp_t e;
      @(negedge clk);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk1("rvalid_p0", p0_rvalid, (e.port == 1'b0));
         chk1("rvalid_p1", p1_rvalid, (e.port == 1'b1));
         chkd("rdata", (e.port ? p1_rdata : p0_rdata), e.data);
      end else begin
         chk1("idle_rvalid_p0", p0_rvalid, 1'b0);
         chk1("idle_rvalid_p1", p1_rvalid, 1'b0);
         chkd("idle_rdata_p0", p0_rdata, '0);
      end
      chk1("gnt_onehot", (p0_gnt & p1_gnt), 1'b0);
      g0 = p0_gnt;
      g1 = p1_gnt;
      if (p0_gnt) begin
         chka("mux_adr_p0", ram_adr, p0_addr);
         chk1("mux_we_p0", ram_we, p0_we);
         if (p0_we) begin
            chkd("mux_d_p0", ram_d, p0_wdata);
            ref_mem[p0_addr] = p0_wdata;
         end else begin
            sbq.push_back('{port: 1'b0, data: ref_mem[p0_addr]});
         end
      end
      if (p1_gnt) begin
         chka("mux_adr_p1", ram_adr, p1_addr);
         chk1("mux_we_p1", ram_we, p1_we);
         if (p1_we) begin
            chkd("mux_d_p1", ram_d, p1_wdata);
            ref_mem[p1_addr] = p1_wdata;
         end else begin
            sbq.push_back('{port: 1'b1, data: ref_mem[p1_addr]});
         end
      end
   endtask

   // Step past the active edge; a granted request is withdrawn.
   task automatic adv();
      @(posedge clk);
      #1;
      if (g0) p0_req = 1'b0;
      if (g1) p1_req = 1'b0;
   endtask

   task automatic clear_ref();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk1({tag, "_init_done"}, init_done, 1'b0);
      chk1({tag, "_gnt0"}, p0_gnt, 1'b0);
      chk1({tag, "_gnt1"}, p1_gnt, 1'b0);
      chk1({tag, "_rvalid0"}, p0_rvalid, 1'b0);
      chk1({tag, "_rvalid1"}, p1_rvalid, 1'b0);
      chkd({tag, "_rdata0"}, p0_rdata, '0);
      chkd({tag, "_rdata1"}, p1_rdata, '0);
      chk1({tag, "_ram_we"}, ram_we, 1'b0);
      chka({tag, "_ram_adr"}, ram_adr, '0);
      chkd({tag, "_ram_d"}, ram_d, '0);
   endtask

   initial begin
      rst = 1'b1; init_req = 1'b0;
      p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
      g0 = 1'b0; g1 = 1'b0;
      clear_ref();

      // Reset state, with a p0 read already pending from cycle 0.
      p0_req = 1'b1; p0_addr = 11'h003;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst = 1'b0;

      // First initialization sweep.
      for (int i = 0; i < DEPTH; i++) begin
         sample();
         chk1("sweep_we", ram_we, 1'b1);
         chka("sweep_adr", ram_adr, AW'(i));
         chkd("sweep_d", ram_d, '0);
         chk1("sweep_done", init_done, 1'b0);
         chk1("sweep_gnt0", p0_gnt, 1'b0);
         adv();
      end
      sample();
      chk1("run_done", init_done, 1'b1);
      chk1("first_gnt0", p0_gnt, 1'b1);
      adv();

      // Single-port write then read.
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 11'h010; p0_wdata = 39'h7F_1234_5678;
      sample();
      chk1("wr_gnt0", p0_gnt, 1'b1);
      chk1("wr_we", ram_we, 1'b1);
      adv();
      p0_req = 1'b1; p0_we = 1'b0;
      sample();
      chk1("rd_gnt0", p0_gnt, 1'b1);
      adv();
      sample();
      chk1("rd_rvalid0", p0_rvalid, 1'b1);
      chkd("rd_rdata0", p0_rdata, 39'h7F_1234_5678);
      chk1("rd_rvalid1", p1_rvalid, 1'b0);
      adv();

      // Back-to-back mixed access to address 5.
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 11'h005; p1_wdata = 39'h55;
      sample();
      chk1("p1_wr_gnt", p1_gnt, 1'b1);
      adv();
      p1_req = 1'b1; p1_we = 1'b0;
      sample();
      adv();
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 11'h005; p0_wdata = 39'h66;
      sample();
      chk1("mix_rvalid1_a", p1_rvalid, 1'b1);
      chkd("mix_rdata1_a", p1_rdata, 39'h55);
      chk1("mix_wr_gnt0", p0_gnt, 1'b1);
      adv();
      p0_we = 1'b0; p0_addr = 11'h010;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 11'h005;
      sample();
      chk1("mix_rd_gnt1", p1_gnt, 1'b1);
      adv();
      sample();
      chk1("mix_rvalid1_b", p1_rvalid, 1'b1);
      chkd("mix_rdata1_b", p1_rdata, 39'h66);
      adv();

      // Contention: continuous reads from both ports.
      for (int k = 0; k < 6; k++) begin
         p0_req = 1'b1; p0_we = 1'b0; p0_addr = 11'h010;
         p1_req = 1'b1; p1_we = 1'b0; p1_addr = 11'h005;
         sample();
         chk1("rr_gnt0", p0_gnt, (k % 2 == 0));
         chk1("rr_gnt1", p1_gnt, (k % 2 == 1));
         adv();
      end
      p0_req = 1'b0; p1_req = 1'b0;
      sample();
      adv();

      // init_req while a read is in flight and p1 is waiting.
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 11'h010;
      sample();
      chk1("ir_gnt0", p0_gnt, 1'b1);
      adv();
      init_req = 1'b1;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 11'h005;
      sample();
      chk1("ir_rvalid0", p0_rvalid, 1'b1);
      chk1("ir_gnt0_off", p0_gnt, 1'b0);
      chk1("ir_gnt1_off", p1_gnt, 1'b0);
      chk1("ir_we_off", ram_we, 1'b0);
      adv();
      init_req = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         sample();
         chk1("sweep2_done", init_done, 1'b0);
         chk1("sweep2_we", ram_we, 1'b1);
         chka("sweep2_adr", ram_adr, AW'(i));
         chkd("sweep2_d", ram_d, '0);
         chk1("sweep2_gnt1", p1_gnt, 1'b0);
         adv();
      end
      clear_ref();
      sample();
      chk1("sweep2_run", init_done, 1'b1);
      chk1("pend_gnt1", p1_gnt, 1'b1);
      adv();
      sample();
      chk1("pend_rvalid1", p1_rvalid, 1'b1);
      chkd("pend_rdata1", p1_rdata, '0);
      adv();

      // Restart a sweep, poke init_req during INIT, then reset mid-sweep.
      init_req = 1'b1;
      sample();
      adv();
      init_req = 1'b0;
      for (int i = 0; i <= 1000; i++) begin
         sample();
         chk1("sweep3_we", ram_we, 1'b1);
         chka("sweep3_adr", ram_adr, AW'(i));
         if (i < 1000) begin
            adv();
            init_req = (i == 499);
         end
      end
      #1;
      rst = 1'b1;
      #1;
      chk_reset_vals("async");
      sbq.delete();
      adv();
      rst = 1'b0;
      for (int j = 0; j < 4; j++) begin
         sample();
         chk1("restart_we", ram_we, 1'b1);
         chka("restart_adr", ram_adr, AW'(j));
         adv();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
